// File: rtl/mem_pkg.sv
// Shared widths and arbiter state encoding for the cache/memory block interface.
package mem_pkg;
    localparam int C_BLOCK_SIZE = 2;
    localparam int C_LINE_SIZE  = 64;
    localparam int ADDRESS_SIZE = 32;
    localparam int BLK_W        = (2**C_BLOCK_SIZE) * C_LINE_SIZE;
    localparam int BADDR_W      = ADDRESS_SIZE - C_BLOCK_SIZE - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Two-request round-robin pick, purely combinational; rr breaks ties.
// No state and no backpressure; the caller decides when to take the grant.
module rr_picker (
    input  logic req0,
    input  logic req1,
    input  logic rr,
    output logic gnt_vld,
    output logic gnt
);
    assign gnt_vld = req0 | req1;
    assign gnt     = (req0 & req1) ? rr : req1;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between two caches; grant registered one edge after request, done/busywait combinational.
// Non-owners are held in busywait; a writeback followed by its refill read stays with the same owner.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter  int c_block_size = C_BLOCK_SIZE,
    parameter  int c_line_size  = C_LINE_SIZE,
    parameter  int address_size = ADDRESS_SIZE,
    localparam int blk_w        = (2**c_block_size) * c_line_size,
    localparam int baddr_w      = address_size - c_block_size - 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               r0_read_i,
    input  logic               r1_read_i,
    input  logic               r0_wr_i,
    input  logic               r1_wr_i,
    input  logic [baddr_w-1:0] r0_address_i,
    input  logic [baddr_w-1:0] r1_address_i,
    input  logic [blk_w-1:0]   r0_write_data_i,
    input  logic [blk_w-1:0]   r1_write_data_i,
    output logic               r0_busywait_o,
    output logic               r1_busywait_o,
    output logic [blk_w-1:0]   r0_read_data_o,
    output logic [blk_w-1:0]   r1_read_data_o,
    output logic               r0_read_done_o,
    output logic               r1_read_done_o,
    output logic               r0_write_done_o,
    output logic               r1_write_done_o,
    output logic               m_read_o,
    output logic               m_wr_o,
    output logic [baddr_w-1:0] m_address_o,
    output logic [blk_w-1:0]   m_write_data_o,
    input  logic               m_busywait_i,
    input  logic               m_read_done_i,
    input  logic               m_write_done_i,
    input  logic [blk_w-1:0]   m_read_data_i
);
    arb_state_t state;
    logic       rr;
    logic       lock;

    logic req0, req1;
    logic own0, own1;
    logic pick_vld, pick;
    logic cur_k, cur_req, cur_rd;
    logic done_any;

    assign req0     = r0_read_i | r0_wr_i;
    assign req1     = r1_read_i | r1_wr_i;
    assign own0     = (state == OWN0);
    assign own1     = (state == OWN1);
    assign cur_k    = own1;
    assign cur_req  = own1 ? req1 : req0;
    assign cur_rd   = own1 ? r1_read_i : r0_read_i;
    assign done_any = m_read_done_i | m_write_done_i;

    rr_picker u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr      (rr),
        .gnt_vld (pick_vld),
        .gnt     (pick)
    );

    // Mirror the owner only while it still requests; a dropped request zeroes the port at once.
    always_comb begin
        m_read_o       = 1'b0;
        m_wr_o         = 1'b0;
        m_address_o    = '0;
        m_write_data_o = '0;
        if (own0 && req0) begin
            m_wr_o         = r0_wr_i;
            m_read_o       = r0_read_i & ~r0_wr_i;
            m_address_o    = r0_address_i;
            m_write_data_o = r0_write_data_i;
        end else if (own1 && req1) begin
            m_wr_o         = r1_wr_i;
            m_read_o       = r1_read_i & ~r1_wr_i;
            m_address_o    = r1_address_i;
            m_write_data_o = r1_write_data_i;
        end
    end

    assign r0_read_done_o  = own0 & m_read_done_i;
    assign r1_read_done_o  = own1 & m_read_done_i;
    assign r0_write_done_o = own0 & m_write_done_i;
    assign r1_write_done_o = own1 & m_write_done_i;
    assign r0_busywait_o   = req0 & ~(own0 & done_any);
    assign r1_busywait_o   = req1 & ~(own1 & done_any);
    assign r0_read_data_o  = m_read_data_i;
    assign r1_read_data_o  = m_read_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
            rr    <= 1'b0;
            lock  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lock <= 1'b0;
                    if (pick_vld) state <= pick ? OWN1 : OWN0;
                end
                OWN0, OWN1: begin
                    if (m_read_done_i) begin
                        state <= IDLE;
                        rr    <= ~cur_k;
                        lock  <= 1'b0;
                    end else if (m_write_done_i) begin
                        lock <= 1'b1;
                    end else if (lock) begin
                        // Only an immediate refill read keeps the grant after a writeback.
                        lock <= 1'b0;
                        if (!cur_rd) begin
                            state <= IDLE;
                            rr    <= ~cur_k;
                        end
                    end else if (!cur_req) begin
                        state <= m_busywait_i ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (!m_busywait_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table with driven memory handshakes, then
// hand sequences against a small block-memory model.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic               clk;
    logic               reset;
    logic               r0_read, r1_read, r0_wr, r1_wr;
    logic [BADDR_W-1:0] r0_addr, r1_addr;
    logic [BLK_W-1:0]   r0_wdata, r1_wdata;
    logic               r0_bw, r1_bw;
    logic [BLK_W-1:0]   r0_rdata, r1_rdata;
    logic               r0_rd_done, r1_rd_done, r0_wr_done, r1_wr_done;
    logic               m_read, m_wr;
    logic [BADDR_W-1:0] m_addr;
    logic [BLK_W-1:0]   m_wdata;
    logic               m_bw, m_rd_done, m_wr_done;

    // Memory-side inputs come either from the vector table or from the model.
    logic               use_model;
    logic               tv_bw, tv_rd_done, tv_wr_done;
    logic               mdl_busy, mdl_rd_done, mdl_wr_done, mdl_op_wr;
    logic [1:0]         mdl_cnt;
    logic [5:0]         mdl_addr;
    logic [BLK_W-1:0]   mdl_wdata, mdl_rdata;
    logic [BLK_W-1:0]   mem [64];

    int total = 0;
    int bad   = 0;

    assign m_bw      = use_model ? mdl_busy    : tv_bw;
    assign m_rd_done = use_model ? mdl_rd_done : tv_rd_done;
    assign m_wr_done = use_model ? mdl_wr_done : tv_wr_done;

    mem_arbiter dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .r0_read_i       (r0_read),
        .r1_read_i       (r1_read),
        .r0_wr_i         (r0_wr),
        .r1_wr_i         (r1_wr),
        .r0_address_i    (r0_addr),
        .r1_address_i    (r1_addr),
        .r0_write_data_i (r0_wdata),
        .r1_write_data_i (r1_wdata),
        .r0_busywait_o   (r0_bw),
        .r1_busywait_o   (r1_bw),
        .r0_read_data_o  (r0_rdata),
        .r1_read_data_o  (r1_rdata),
        .r0_read_done_o  (r0_rd_done),
        .r1_read_done_o  (r1_rd_done),
        .r0_write_done_o (r0_wr_done),
        .r1_write_done_o (r1_wr_done),
        .m_read_o        (m_read),
        .m_wr_o          (m_wr),
        .m_address_o     (m_addr),
        .m_write_data_o  (m_wdata),
        .m_busywait_i    (m_bw),
        .m_read_done_i   (m_rd_done),
        .m_write_done_i  (m_wr_done),
        .m_read_data_i   (mdl_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BLK_W-1:0] blk(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + i;
        return {8{w}};
    endfunction

    // Block memory model: accepts a request, stays busy for 3 cycles, then pulses done.
    always @(posedge clk) begin
        mdl_rd_done <= 1'b0;
        mdl_wr_done <= 1'b0;
        if (reset) begin
            mdl_busy  <= 1'b0;
            mdl_cnt   <= 2'd0;
            mdl_rdata <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= blk(i);
        end else if (mdl_busy) begin
            if (mdl_cnt == 2'd0) begin
                mdl_busy <= 1'b0;
                if (mdl_op_wr) begin
                    mem[mdl_addr] <= mdl_wdata;
                    mdl_wr_done   <= 1'b1;
                end else begin
                    mdl_rdata   <= mem[mdl_addr];
                    mdl_rd_done <= 1'b1;
                end
            end else begin
                mdl_cnt <= mdl_cnt - 2'd1;
            end
        end else if (!(mdl_rd_done || mdl_wr_done) && (m_read || m_wr)) begin
            mdl_busy  <= 1'b1;
            mdl_cnt   <= 2'd2;
            mdl_op_wr <= m_wr;
            mdl_addr  <= m_addr[5:0];
            mdl_wdata <= m_wdata;
        end
    end

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // in_v = {rst, r0rd, r0wr, r1rd, r1wr, m_busywait, m_read_done, m_write_done}
    // ex_v = {m_read, m_wr, r0_bw, r1_bw, r0_rd_done, r1_rd_done, r0_wr_done, r1_wr_done}
    typedef struct packed {
        logic [7:0] in_v;
        logic [7:0] ex_v;
        logic [7:0] ex_addr;
    } vec_t;

    vec_t tv [37];

    bit seen, r1_early;
    logic [BLK_W-1:0] cap_data;
    logic [BADDR_W-1:0] cap_addr;
    logic [7:0] act_v;

    initial begin
        tv[0]  = '{8'b1100_0000, 8'b0010_0000, 8'h00};
        tv[1]  = '{8'b1100_0000, 8'b0010_0000, 8'h00};
        tv[2]  = '{8'b0100_0000, 8'b0010_0000, 8'h00};
        tv[3]  = '{8'b0100_0100, 8'b1010_0000, 8'h03};
        tv[4]  = '{8'b0100_0010, 8'b1000_1000, 8'h03};
        tv[5]  = '{8'b0000_0000, 8'b0000_0000, 8'h00};
        tv[6]  = '{8'b0101_0000, 8'b0011_0000, 8'h00};
        tv[7]  = '{8'b0101_0100, 8'b1011_0000, 8'h11};
        tv[8]  = '{8'b0101_0010, 8'b1010_0100, 8'h11};
        tv[9]  = '{8'b0100_0000, 8'b0010_0000, 8'h00};
        tv[10] = '{8'b0100_0100, 8'b1010_0000, 8'h03};
        tv[11] = '{8'b0110_0100, 8'b0110_0000, 8'h03};
        tv[12] = '{8'b0000_0100, 8'b0000_0000, 8'h00};
        tv[13] = '{8'b0001_0100, 8'b0001_0000, 8'h00};
        tv[14] = '{8'b0001_0010, 8'b0001_0000, 8'h00};
        tv[15] = '{8'b0001_0000, 8'b0001_0000, 8'h00};
        tv[16] = '{8'b0001_0100, 8'b1001_0000, 8'h11};
        tv[17] = '{8'b0000_0000, 8'b0000_0000, 8'h00};
        tv[18] = '{8'b0010_0000, 8'b0010_0000, 8'h00};
        tv[19] = '{8'b0011_0100, 8'b0111_0000, 8'h03};
        tv[20] = '{8'b0011_0001, 8'b0101_0010, 8'h03};
        tv[21] = '{8'b0101_0000, 8'b1011_0000, 8'h03};
        tv[22] = '{8'b0101_0100, 8'b1011_0000, 8'h03};
        tv[23] = '{8'b0101_0010, 8'b1001_1000, 8'h03};
        tv[24] = '{8'b0001_0000, 8'b0001_0000, 8'h00};
        tv[25] = '{8'b0001_0100, 8'b1001_0000, 8'h11};
        tv[26] = '{8'b0001_0010, 8'b1000_0100, 8'h11};
        tv[27] = '{8'b0010_0000, 8'b0010_0000, 8'h00};
        tv[28] = '{8'b0011_0001, 8'b0101_0010, 8'h03};
        tv[29] = '{8'b0001_0000, 8'b0001_0000, 8'h00};
        tv[30] = '{8'b0000_1000, 8'b0001_0000, 8'h00};
        tv[31] = '{8'b1000_1100, 8'b0101_0000, 8'h11};
        tv[32] = '{8'b0100_1000, 8'b0011_0000, 8'h00};
        tv[33] = '{8'b0100_1100, 8'b1011_0000, 8'h03};
        tv[34] = '{8'b0100_1010, 8'b1001_1000, 8'h03};
        tv[35] = '{8'b0000_1000, 8'b0001_0000, 8'h00};
        tv[36] = '{8'b0000_1100, 8'b0101_0000, 8'h11};

        use_model = 1'b0;
        reset = 1'b1;
        {r0_read, r0_wr, r1_read, r1_wr} = 4'b0;
        {tv_bw, tv_rd_done, tv_wr_done} = 3'b0;
        r0_addr  = BADDR_W'(32'h3);
        r1_addr  = BADDR_W'(32'h11);
        r0_wdata = blk(100);
        r1_wdata = blk(101);
        @(posedge clk); #1;

        for (int i = 0; i < 37; i++) begin
            {reset, r0_read, r0_wr, r1_read, r1_wr, tv_bw, tv_rd_done, tv_wr_done} = tv[i].in_v;
            @(negedge clk);
            act_v = {m_read, m_wr, r0_bw, r1_bw, r0_rd_done, r1_rd_done, r0_wr_done, r1_wr_done};
            check($sformatf("row%0d_ctl", i), BLK_W'(act_v), BLK_W'(tv[i].ex_v));
            check($sformatf("row%0d_addr", i), BLK_W'(m_addr), BLK_W'(tv[i].ex_addr));
            @(posedge clk); #1;
        end

        // Model-backed sequences from a fresh reset.
        use_model = 1'b1;
        reset = 1'b1;
        {r0_read, r0_wr, r1_read, r1_wr} = 4'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single read of block 3 by r0.
        r0_read = 1'b1;
        r0_addr = BADDR_W'(32'h3);
        seen = 1'b0;
        r1_early = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (r1_rd_done) r1_early = 1'b1;
            if (r0_rd_done) begin
                seen = 1'b1;
                cap_data = r0_rdata;
                cap_addr = m_addr;
            end
        end
        check("rd3_done_seen", BLK_W'(seen), BLK_W'(1'b1));
        check("rd3_data", cap_data, blk(3));
        check("rd3_addr", BLK_W'(cap_addr), BLK_W'(32'h3));
        check("rd3_no_r1_done", BLK_W'(r1_early), BLK_W'(1'b0));
        @(posedge clk); #1 r0_read = 1'b0;

        // Writeback of block 7 then refill of 0x27, with r1 pending throughout.
        r0_wr    = 1'b1;
        r0_addr  = BADDR_W'(32'h7);
        r0_wdata = BLK_W'(32'h38);
        @(posedge clk); #1;
        r1_read = 1'b1;
        r1_addr = BADDR_W'(32'h9);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if ((m_read && m_addr == BADDR_W'(32'h9)) || !r1_bw) r1_early = 1'b1;
            if (r0_wr_done) seen = 1'b1;
        end
        check("wb_done_seen", BLK_W'(seen), BLK_W'(1'b1));
        @(posedge clk); #1;
        r0_wr   = 1'b0;
        r0_read = 1'b1;
        r0_addr = BADDR_W'(32'h27);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if ((m_read && m_addr == BADDR_W'(32'h9)) || !r1_bw) r1_early = 1'b1;
            if (r0_rd_done) begin
                seen = 1'b1;
                cap_data = r0_rdata;
            end
        end
        check("refill_done_seen", BLK_W'(seen), BLK_W'(1'b1));
        check("refill_data", cap_data, blk(39));
        check("refill_atomic", BLK_W'(r1_early), BLK_W'(1'b0));
        @(posedge clk); #1 r0_read = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (r1_rd_done) begin
                seen = 1'b1;
                cap_data = r1_rdata;
            end
        end
        check("r1_done_seen", BLK_W'(seen), BLK_W'(1'b1));
        check("r1_data", cap_data, blk(9));
        check("mem7_written", mem[7], BLK_W'(32'h38));
        @(posedge clk); #1 r1_read = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single block-wide `memory` backing store between two `cache` instances, for example I-side and D-side. It sits between the caches' memory-side ports and the memory. It grants one cache at a time, forwards that cache's block read or write, routes completion pulses back to the owner, and holds every other requester in busywait. Arbitration is round-robin, and a dirty writeback followed by its refill read is kept atomic.

## Interface
Parameters:
- `c_block_size`, 2: log2 of words per block.
- `c_line_size`, 64: word width in bits.
- `address_size`, 32: CPU address width.
- Derived `BLK_W` = 2**c_block_size*c_line_size (256).
- Derived `BADDR_W` = address_size-c_block_size-2 (28).

Ports. Reset is synchronous and active-high (`reset_i`, one clock `clk_i`):
- `clk_i` in 1: sole clock, rising edge.
- `reset_i` in 1: synchronous, active-high.
- `r0_read_i`, `r1_read_i` in 1: block read request, held until done.
- `r0_wr_i`, `r1_wr_i` in 1: block write request, held until done.
- `r0_address_i`, `r1_address_i` in BADDR_W: block address.
- `r0_write_data_i`, `r1_write_data_i` in BLK_W: block write data.
- `r0_busywait_o`, `r1_busywait_o` out 1: requester must hold its request.
- `r0_read_data_o`, `r1_read_data_o` out BLK_W: block read data.
- `r0_read_done_o`, `r1_read_done_o`, `r0_write_done_o`, `r1_write_done_o` out 1: completion pulses, owner only.
- `m_read_o`, `m_wr_o` out 1: memory request.
- `m_address_o` out BADDR_W; `m_write_data_o` out BLK_W.
- `m_busywait_i`, `m_read_done_i`, `m_write_done_i` in 1; `m_read_data_i` in BLK_W.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0, OWN1: requester k owns memory.
  - DRAIN: owner dropped its request early; waits for memory to go idle.
- Priority pointer `rr` (1 bit) names the preferred requester.
- IDLE: if only one requester has read|wr asserted, go to that OWNk. If both do, go to OWN`rr`.
- OWNk:
  - The memory port mirrors requester k's read, wr, address and write data combinationally.
  - `m_read_done_i` and `m_write_done_i` route to k's done outputs only.
  - `m_read_data_i` is broadcast to both `read_data_o` buses.
- Leaving OWNk on a done pulse:
  - Read done: go to IDLE and set `rr` = ~k.
  - Write done: set a one-cycle `lock` flag and stay in OWNk. If k asserts read in the next cycle (refill), ownership continues. Otherwise go to IDLE with `rr` = ~k.
- OWNk, k drops read|wr with no done: if `m_busywait_i`=0, go to IDLE; otherwise go to DRAIN. Memory outputs are forced low from that cycle.
- DRAIN: memory outputs low. Go to IDLE when `m_busywait_i`=0. Done pulses arriving in DRAIN are discarded.
- Read and wr both asserted by one requester is illegal. The arbiter forwards wr only (`m_read_o`=0).
- A non-owner requesting at any time: busywait=1, done=0. Its request is not dropped.
- Addresses are passed through unmodified; there is no width arithmetic.

## Timing
- Reset (edge with `reset_i`=1): state IDLE, `rr`=0, `lock`=0. All `m_*_o` are 0, all done outputs are 0, `read_data_o` follows the input (broadcast).
- Reset mid-transaction aborts the grant at that edge. Memory is reset on the same edge.
- Grant latency: a request first seen in IDLE at edge t sets state OWNk at edge t. `m_read_o`/`m_wr_o` rise after edge t, one cycle after the request.
- `rk_busywait_o` = (read|wr) & ~(owner k & done pulse this cycle). It is combinational, so it goes low in the done cycle.
- Done outputs are combinational from the memory inputs: zero added latency.
- After a read done, the other requester's pending request is granted at the next edge. The re-arbitration gap is one cycle.
- Refill after writeback: the read must be asserted in the cycle immediately following the write done. This matches cache writeback→read sequencing.

## Structure
- A shared package `mem_pkg` holds:
  - the derived widths BLK_W and BADDR_W;
  - the FSM state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2, DRAIN=2'd3).
- `memory` and `cache` import `mem_pkg` for the same widths.
- One sub-module is natural: `rr_picker` (2-request round-robin, combinational grant from `rr`).
- The mux and FSM stay in `mem_arbiter`.

## Test plan
- Reset held for 2 cycles with r0_read=1 → all m_*_o=0 and both busywait outputs track requests. First `m_read_o` appears 1 cycle after reset release, with `m_address_o`=r0 address.
- r0 read addr 0x3 alone → `m_address_o`=0x3, and `r0_read_data_o` equals memory block 3 on `r0_read_done_o`. `r1_read_done_o` stays 0.
- r0 and r1 read in the same cycle after reset → r0 served first (rr=0). r1 is granted 1 cycle after r0's done, and r1_busywait=1 throughout r0's transfer.
- r0 write 0x38 to block 0x7 then read block 0x27 on the next cycle, with r1 requesting throughout → the r0 write and read happen back-to-back with no r1 grant in between. r1 is then served, and memory block 7 = 0x38.
- r1 drops its read mid-transfer while `m_busywait_i`=1 → state DRAIN and `m_read_o`=0. The late `m_read_done_i` is not seen on r1, and the pending r0 request is granted after busywait falls.
- Reset asserted during an r1 write → next edge m_wr_o=0 and state IDLE. After release, r0 is granted first on a simultaneous request.
